// File: rtl/dma_pkt_unpacker_pkg.sv
// Shared constants, state encoding, beat payload and keep helper for the DMA packet unpacker.
package dma_pkt_pkg;

    localparam int unsigned DWIDTH        = 64;
    localparam int unsigned KWIDTH        = DWIDTH / 8;
    localparam int unsigned HDR_LEN_LSB   = 0;
    localparam int unsigned LWIDTH        = 16;
    localparam int unsigned MAX_PKT_BYTES = 9600;
    localparam int unsigned CWIDTH        = 16;
    // Wide enough for ceil((2^LWIDTH-1)/8) so an oversized header cannot wrap before it is rejected.
    localparam int unsigned WCNT_WIDTH    = LWIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA
    } pkt_state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [KWIDTH-1:0] keep;
        logic              last;
    } axis_beat_t;

    function automatic logic [KWIDTH-1:0] keep_from_len(input logic [2:0] rem);
        if (rem == 3'd0) begin
            return '1;
        end
        return (KWIDTH'(1) << rem) - KWIDTH'(1);
    endfunction

endpackage

// File: rtl/dma_pkt_unpacker_if.sv
// FIFO pull side and AXI-stream master side of the packet unpacker.
interface dma_pkt_unpacker_if;
    import dma_pkt_pkg::*;

    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_data;
    logic              fifo_pull;
    logic [DWIDTH-1:0] m_tdata;
    logic [KWIDTH-1:0] m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;

    modport master (
        input  fifo_empty, fifo_data, m_tready,
        output fifo_pull, m_tdata, m_tkeep, m_tvalid, m_tlast
    );

    modport slave (
        output fifo_empty, fifo_data, m_tready,
        input  fifo_pull, m_tdata, m_tkeep, m_tvalid, m_tlast
    );

endinterface

// File: rtl/dma_pkt_unpacker.sv
// Pops header+data words from the DMA packet FIFO and emits AXI-stream beats with tkeep/tlast.
module dma_pkt_unpacker
    import dma_pkt_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    dma_pkt_unpacker_if.master  pkt_if,
    output logic                pkt_done_o,
    output logic                pkt_err_o,
    output logic [CWIDTH-1:0]   pkt_cnt_o,
    output logic [CWIDTH-1:0]   err_cnt_o
);

    pkt_state_t             state_q, state_d;
    logic [WCNT_WIDTH-1:0]  words_left_q, words_left_d;
    logic [KWIDTH-1:0]      last_keep_q, last_keep_d;
    axis_beat_t             beat_q, beat_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CWIDTH-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic [CWIDTH-1:0]      err_cnt_q, err_cnt_d;
    logic [LWIDTH-1:0]      hdr_len;
    logic                   last_word;
    logic                   ld;
    logic                   pull;

    assign hdr_len   = pkt_if.fifo_data[HDR_LEN_LSB +: LWIDTH];
    assign last_word = (words_left_q == WCNT_WIDTH'(1));

    // Next-state, counters and output-register load.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        last_keep_d  = last_keep_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;
        ld           = 1'b0;
        pull         = 1'b0;
        done_d       = valid_q && pkt_if.m_tready && beat_q.last;
        pkt_cnt_d    = done_d ? pkt_cnt_q + CWIDTH'(1) : pkt_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i && !pkt_if.fifo_empty) begin
                    pull         = 1'b1;
                    words_left_d = WCNT_WIDTH'((17'(hdr_len) + 17'd7) >> 3);
                    last_keep_d  = keep_from_len(hdr_len[2:0]);
                    if ((hdr_len == '0) || (32'(hdr_len) > MAX_PKT_BYTES)) begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CWIDTH'(1);
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ld   = !pkt_if.fifo_empty && (!valid_q || pkt_if.m_tready);
                pull = ld;
                if (ld) begin
                    beat_d.data  = pkt_if.fifo_data;
                    beat_d.last  = last_word;
                    beat_d.keep  = last_word ? last_keep_q : '1;
                    valid_d      = 1'b1;
                    words_left_d = words_left_q - WCNT_WIDTH'(1);
                    if (last_word) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accepted beat with nothing behind it: drop valid, keep payload.
        if (valid_q && pkt_if.m_tready && !ld) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            last_keep_q  <= '0;
            beat_q       <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            last_keep_q  <= last_keep_d;
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign pkt_if.fifo_pull = pull;
    assign pkt_if.m_tdata   = beat_q.data;
    assign pkt_if.m_tkeep   = beat_q.keep;
    assign pkt_if.m_tlast   = beat_q.last;
    assign pkt_if.m_tvalid  = valid_q;
    assign pkt_done_o       = done_q;
    assign pkt_err_o        = err_q;
    assign pkt_cnt_o        = pkt_cnt_q;
    assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_dma_pkt_unpacker.sv
// Randomized bench: FIFO model + packet-level expected-beat queue, checked every cycle.
module tb_dma_pkt_unpacker;
    import dma_pkt_pkg::*;

    typedef struct { logic [63:0] w; int tag; } fword_t;   // tag: 0 data, 1 good header, 2 bad header
    typedef struct { logic [63:0] d; logic [7:0] k; logic l; } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        pkt_done, pkt_err;
    logic [15:0] pkt_cnt, err_cnt;

    dma_pkt_unpacker_if dif();

    dma_pkt_unpacker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable),
        .pkt_if     (dif),
        .pkt_done_o (pkt_done),
        .pkt_err_o  (pkt_err),
        .pkt_cnt_o  (pkt_cnt),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    fword_t      fifo_q[$];
    beat_t       exp_q[$];
    int          n_vec = 0, n_err = 0, cyc = 0;
    logic        hs_last_prev = 0, pop_bad_prev = 0, held_prev = 0, valid_prev = 0, pop_now = 0;
    beat_t       held;
    logic [15:0] exp_pkt_cnt = 0, exp_err_cnt = 0;
    int          hdr_pull_cyc = -1, rise_cyc = -1;
    int          hs_count = 0, first_hs_cyc = 0, last_hs_cyc = 0, err_pulses = 0;
    int          ready_mode = 0;
    bit          rand_empty = 0, rand_enable = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_keep(input int len);
        int r = len % 8;
        if (r == 0) return 8'hFF;
        return 8'((1 << r) - 1);
    endfunction

    function automatic int m_beats(input int len);
        return (len + 7) / 8;
    endfunction

    function automatic bit m_bad(input int len);
        return (len == 0) || (len > 9600);
    endfunction

    task automatic push_pkt(input int len);
        logic [63:0] h, d;
        int nb;
        h = {32'($urandom), 32'($urandom)};
        h[15:0] = 16'(len);
        if (m_bad(len)) begin
            fifo_q.push_back('{h, 2});
        end else begin
            fifo_q.push_back('{h, 1});
            nb = m_beats(len);
            for (int i = 0; i < nb; i++) begin
                d = {32'($urandom), 32'($urandom)};
                fifo_q.push_back('{d, 0});
                exp_q.push_back('{d, (i == nb - 1) ? m_keep(len) : 8'hFF, i == nb - 1});
            end
        end
    endtask

    task automatic drive();
        dif.fifo_empty = (fifo_q.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
        dif.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0].w : {32'($urandom), 32'($urandom)};
        dif.m_tready   = (ready_mode == 0) ? 1'b1 :
                         (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        enable         = rand_enable ? ($urandom_range(0, 7) != 0) : 1'b1;
    endtask

    // One cycle: check at negedge, apply the FIFO pop and new inputs just after posedge.
    task automatic step();
        logic exp_done, exp_err;
        beat_t b;
        @(negedge clk);
        cyc++;
        chk("pull_while_empty", 64'(dif.fifo_pull && dif.fifo_empty), 0);
        exp_done = hs_last_prev;
        exp_err  = pop_bad_prev;
        if (exp_done) exp_pkt_cnt++;
        if (exp_err && exp_err_cnt != 16'hFFFF) exp_err_cnt++;
        if (pkt_err) err_pulses++;
        chk("pkt_done", 64'(pkt_done), 64'(exp_done));
        chk("pkt_err", 64'(pkt_err), 64'(exp_err));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));
        chk("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
        if (held_prev) begin
            chk("hold_valid", 64'(dif.m_tvalid), 1);
            chk("hold_tdata", dif.m_tdata, held.d);
            chk("hold_tkeep", 64'(dif.m_tkeep), 64'(held.k));
            chk("hold_tlast", 64'(dif.m_tlast), 64'(held.l));
        end
        if (dif.m_tvalid && !valid_prev && rise_cyc < 0) rise_cyc = cyc;
        if (dif.m_tvalid && dif.m_tready) begin
            if (hs_count == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                chk("tdata", dif.m_tdata, b.d);
                chk("tkeep", 64'(dif.m_tkeep), 64'(b.k));
                chk("tlast", 64'(dif.m_tlast), 64'(b.l));
            end
        end
        hs_last_prev = dif.m_tvalid && dif.m_tready && dif.m_tlast;
        held_prev    = dif.m_tvalid && !dif.m_tready;
        held         = '{dif.m_tdata, dif.m_tkeep, dif.m_tlast};
        valid_prev   = dif.m_tvalid;
        pop_now      = dif.fifo_pull && (fifo_q.size() != 0);
        pop_bad_prev = pop_now && (fifo_q[0].tag == 2);
        if (pop_now && fifo_q[0].tag == 1) hdr_pull_cyc = cyc;
        @(posedge clk);
        #1;
        if (pop_now) fifo_q.delete(0);
        drive();
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || dif.m_tvalid) && k < bound) begin
            step();
            k++;
        end
        if (k >= bound) chk("drain_timeout", 1, 0);
        repeat (3) step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, len, r;
        dif.fifo_empty = 1'b1;
        dif.fifo_data  = '0;
        dif.m_tready   = 1'b0;
        #1 rst_n = 1'b0;
        #10;
        chk("rst_tvalid", 64'(dif.m_tvalid), 0);
        chk("rst_tdata", dif.m_tdata, 0);
        chk("rst_tkeep", 64'(dif.m_tkeep), 0);
        chk("rst_cnts", 64'({pkt_cnt, err_cnt, 6'd0, pkt_done, pkt_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Model pins against hand-computed values.
        chk("model_keep13", 64'(m_keep(13)), 64'h1F);
        chk("model_keep1", 64'(m_keep(1)), 64'h01);
        chk("model_keep16", 64'(m_keep(16)), 64'hFF);
        chk("model_beats13", 64'(m_beats(13)), 2);

        // 1: len=16, latency header->tvalid is two cycles.
        push_pkt(16);
        drive();
        drain(200);
        chk("t1_latency", 64'(rise_cyc - hdr_pull_cyc), 2);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 1);

        // 2: partial last words.
        push_pkt(13);
        push_pkt(1);
        drive();
        drain(200);
        chk("t2_pkt_cnt", 64'(pkt_cnt), 3);

        // 3: back-pressure on beat 1 for 5 cycles.
        ready_mode = 2;
        push_pkt(24);
        drive();
        k = 0;
        while (!dif.m_tvalid && k < 20) begin step(); k++; end
        chk("t3_valid_seen", 64'(dif.m_tvalid), 1);
        repeat (5) begin
            step();
            chk("t3_no_pull", 64'(dif.fifo_pull), 0);
        end
        ready_mode = 0;
        drive();
        drain(200);
        chk("t3_pkt_cnt", 64'(pkt_cnt), 4);

        // 4: bad headers are dropped.
        err_pulses = 0;
        push_pkt(0);
        push_pkt(9601);
        push_pkt(8);
        drive();
        drain(200);
        chk("t4_err_pulses", 64'(err_pulses), 2);
        chk("t4_err_cnt", 64'(err_cnt), 2);
        chk("t4_pkt_cnt", 64'(pkt_cnt), 5);

        // 5: three back-to-back 64-byte packets, one bubble each between.
        hs_count = 0;
        repeat (3) push_pkt(64);
        drive();
        drain(200);
        chk("t5_beats", 64'(hs_count), 24);
        chk("t5_span", 64'(last_hs_cyc - first_hs_cyc), 25);
        chk("t5_pkt_cnt", 64'(pkt_cnt), 8);
        rand_empty = 1;
        repeat (3) push_pkt(64);
        drive();
        drain(400);
        rand_empty = 0;

        // 6: reset during beat 3 of 8.
        push_pkt(64);
        drive();
        hs_count = 0;
        k = 0;
        while (hs_count < 3 && k < 50) begin step(); k++; end
        chk("t6_reached_beat3", 64'(hs_count), 3);
        enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(dif.m_tvalid), 0);
        chk("t6_rst_tlast", 64'(dif.m_tlast), 0);
        chk("t6_rst_tdata", dif.m_tdata, 0);
        chk("t6_rst_tkeep", 64'(dif.m_tkeep), 0);
        chk("t6_rst_pull", 64'(dif.fifo_pull), 0);
        chk("t6_rst_cnts", 64'({pkt_cnt, err_cnt, 6'd0, pkt_done, pkt_err}), 0);
        fifo_q.delete();
        exp_q.delete();
        hs_last_prev = 0; pop_bad_prev = 0; held_prev = 0; valid_prev = 0;
        exp_pkt_cnt = 0; exp_err_cnt = 0;
        dif.fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_pkt(20);
        drive();
        drain(200);
        chk("t6_pkt_cnt_after", 64'(pkt_cnt), 1);

        // Random traffic: random lengths, bad headers, empty gaps, back-pressure, enable gaps.
        rand_empty = 1; rand_enable = 1; ready_mode = 1;
        push_pkt(9600);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9601, 65535);
            else if (r == 1) len = $urandom_range(1, 2000);
            else             len = $urandom_range(1, 80);
            push_pkt(len);
        end
        drive();
        drain(60000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
